// File: rtl/cpu_core_mc.sv
// Multicycle CPU core: sequencer, PC, register file, ALU, flags, req/ready memory port.
// Optional macro CPU_R0_ZERO_EN makes R0 read as zero and discards writes to it.
module cpu_core_mc #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_REGS   = 16,
    parameter int RESET_PC   = 0
) (
    input  logic                  Clk,
    input  logic                  Rst,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [2:0]            flags,
    output logic                  wb_valid,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  halted,
    output logic                  illegal
);
    localparam int DW = DATA_WIDTH;
    localparam int AW = ADDR_WIDTH;
    localparam logic [AW-1:0] PC0 = AW'(RESET_PC);
`ifdef CPU_R0_ZERO_EN
    localparam int WR_LO = 1;
`else
    localparam int WR_LO = 0;
`endif

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   ir_q, ir_d;
    logic [AW-1:0] pc_q, pc_d, addr_q, addr_d;
    logic [DW-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [DW-1:0] wdata_q, wdata_d, wbd_q, wbd_d;
    logic [2:0]    flags_q, flags_d;
    logic          req_q, req_d, we_q, we_d;
    logic          wbv_q, wbv_d, halt_q, halt_d, ill_q, ill_d;
    logic [DW-1:0] rf_q [NUM_REGS];
    logic [DW-1:0] rf_d [NUM_REGS];

    logic [3:0] op, rd, ext, rs;
    logic [7:0] imm8;
    logic       accept;
    assign op     = ir_q[15:12];
    assign rd     = ir_q[11:8];
    assign ext    = ir_q[7:4];
    assign rs     = ir_q[3:0];
    assign imm8   = ir_q[7:0];
    assign accept = req_q & mem_ready;

    logic is_alu, is_cmp, is_addi, is_movi, is_lui;
    logic is_ld, is_st, is_jr, is_beq, is_halt, is_ill;
    assign is_alu  = (op == 4'h0) && (ext <= 4'h5);
    assign is_cmp  = (op == 4'h0) && (ext == 4'h6);
    assign is_addi = (op == 4'h1);
    assign is_movi = (op == 4'h2);
    assign is_lui  = (op == 4'h3);
    assign is_ld   = (op == 4'h4);
    assign is_st   = (op == 4'h5);
    assign is_jr   = (op == 4'h6);
    assign is_beq  = (op == 4'h7);
    assign is_halt = (op == 4'hF);
    assign is_ill  = !(is_alu | is_cmp | is_addi | is_movi | is_lui |
                       is_ld | is_st | is_jr | is_beq | is_halt);

    // Indices at or above NUM_REGS fall through the loop and read 0
    logic [DW-1:0] rd_val, rs_val;
    always_comb begin
        rd_val = '0;
        rs_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd == 4'(i)) rd_val = rf_q[i];
            if (rs == 4'(i)) rs_val = rf_q[i];
        end
    end

    logic [DW-1:0] imm_s, imm_z, alu_res;
    logic [DW:0]   sum, dif, addi;
    logic          carry, flag_upd;
    logic [2:0]    alu_flags;
    always_comb begin
        imm_z    = DW'(imm8);
        imm_s    = {{(DW-8){imm8[7]}}, imm8};
        sum      = {1'b0, a_q} + {1'b0, b_q};
        dif      = {1'b0, a_q} - {1'b0, b_q};
        addi     = {1'b0, a_q} + {1'b0, imm_s};
        alu_res  = '0;
        carry    = 1'b0;
        flag_upd = 1'b0;
        unique case (1'b1)
            is_addi: begin
                alu_res  = addi[DW-1:0];
                carry    = addi[DW];
                flag_upd = 1'b1;
            end
            is_movi: alu_res = imm_z;
            is_lui:  alu_res = imm_z << 8;
            (op == 4'h0): begin
                unique case (ext)
                    4'h0: begin
                        alu_res  = sum[DW-1:0];
                        carry    = sum[DW];
                        flag_upd = 1'b1;
                    end
                    4'h1, 4'h6: begin
                        alu_res  = dif[DW-1:0];
                        carry    = dif[DW];
                        flag_upd = 1'b1;
                    end
                    4'h2:    alu_res = a_q & b_q;
                    4'h3:    alu_res = a_q | b_q;
                    4'h4:    alu_res = a_q ^ b_q;
                    4'h5:    alu_res = b_q;
                    default: alu_res = '0;
                endcase
            end
            default: alu_res = '0;
        endcase
        alu_flags = {alu_res[DW-1], alu_res == '0, carry};
    end

    // pc_q already points past the branch, so this is branch_addr + 1 + offset
    logic [AW+7:0] br_sum;
    assign br_sum = {8'b0, pc_q} + {{AW{imm8[7]}}, imm8};

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:  if (accept) state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                unique case (1'b1)
                    is_halt:         state_d = S_HALT;
                    (is_ld | is_st): state_d = S_MEM;
                    (is_alu | is_addi | is_movi | is_lui):
                                     state_d = S_WB;
                    default:         state_d = S_FETCH;
                endcase
            end
            S_MEM:    if (accept) state_d = is_st ? S_FETCH : S_WB;
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ir_d    = ir_q;
        pc_d    = pc_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        flags_d = flags_q;
        for (int i = 0; i < NUM_REGS; i++) rf_d[i] = rf_q[i];
        unique case (state_q)
            S_FETCH: begin
                if (accept) begin
                    ir_d = mem_rdata[15:0];
                    pc_d = pc_q + AW'(1);
                end
            end
            S_DECODE: begin
                a_d = rd_val;
                b_d = rs_val;
            end
            S_EXEC: begin
                res_d = alu_res;
                if (flag_upd) flags_d = alu_flags;
                if (is_jr) pc_d = a_q[AW-1:0];
                if (is_beq && flags_q[1]) pc_d = br_sum[AW-1:0];
            end
            S_MEM: if (accept && !is_st) res_d = mem_rdata;
            S_WB: begin
                for (int i = WR_LO; i < NUM_REGS; i++)
                    if (rd == 4'(i)) rf_d[i] = res_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        req_d   = (state_d == S_FETCH) || (state_d == S_MEM);
        we_d    = (state_d == S_MEM) && is_st;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (state_d == S_FETCH) addr_d = pc_d;
        else if (state_d == S_MEM) addr_d = b_q[AW-1:0];
        if (state_d == S_MEM && is_st) wdata_d = a_q;
        wbv_d   = (state_q == S_WB);
        wbd_d   = (state_q == S_WB) ? res_q : wbd_q;
        halt_d  = (state_d == S_HALT);
        ill_d   = (state_q == S_EXEC) && is_ill;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ir_q    <= '0;
            pc_q    <= PC0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            flags_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= PC0;
            wdata_q <= '0;
            wbv_q   <= 1'b0;
            wbd_q   <= '0;
            halt_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= rf_d[i];
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wbv_q   <= wbv_d;
            wbd_q   <= wbd_d;
            halt_q  <= halt_d;
            ill_q   <= ill_d;
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign pc        = pc_q;
    assign flags     = flags_q;
    assign wb_valid  = wbv_q;
    assign wb_data   = wbd_q;
    assign halted    = halt_q;
    assign illegal   = ill_q;
endmodule
